// File: rtl/dispatch_router.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_router
//  Purpose  : Dispatch stage between the decode/rename queue and the
//             reservation stations. It takes one renamed instruction per
//             cycle and resolves both operands from the supplied ARF/ROB
//             values or from the CDB. The instruction is kept in a one-entry
//             buffer that keeps snooping the CDB while it waits. The entry
//             is then offered to one of NUM_CH station channels.
//  Ports    : clk, rst_n (async, active low), flush (sync)
//             in_*      upstream valid/ready handshake, channel, payload,
//                       operand tag/ready/data
//             cdb_*     NUM_CDB packed broadcast ports
//             out_*     one-hot channel valid, per-channel ready, shared
//                       payload and operand outputs
//             err_illegal  1-cycle pulse after dropping an entry with an
//                          out-of-range in_ch
//  Config   : DISPATCH_BYPASS_EN - when defined, an entry that arrives while
//             the buffer is empty and whose channel is ready goes straight
//             through combinationally (0-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
module dispatch_router #(
  parameter int NUM_CH    = 4,
  parameter int NUM_CDB   = 3,
  parameter int ROB_IDX_W = 5,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 128,
  parameter int CH_SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_SEL_W-1:0]          in_ch,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [ROB_IDX_W-1:0]         in_rs1_tag,
  input  logic                         in_rs1_ready,
  input  logic [XLEN-1:0]              in_rs1_data,
  input  logic [ROB_IDX_W-1:0]         in_rs2_tag,
  input  logic                         in_rs2_ready,
  input  logic [XLEN-1:0]              in_rs2_data,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [ROB_IDX_W-1:0]         out_rs1_tag,
  output logic                         out_rs1_ready,
  output logic [XLEN-1:0]              out_rs1_data,
  output logic [ROB_IDX_W-1:0]         out_rs2_tag,
  output logic                         out_rs2_ready,
  output logic [XLEN-1:0]              out_rs2_data,
  output logic                         err_illegal
);

  typedef enum logic [0:0] {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [CH_SEL_W-1:0]    ch_q, ch_d;
  logic [ROB_IDX_W-1:0]   rs1_tag_q, rs1_tag_d, rs2_tag_q, rs2_tag_d;
  logic                   rs1_ready_q, rs1_ready_d, rs2_ready_q, rs2_ready_d;
  logic [XLEN-1:0]        rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic                   err_q, err_d;

  // Returns {hit, data}. The scan runs from the top port down, so the
  // lowest-index matching port wins.
  function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_IDX_W-1:0] tag);
    logic [XLEN:0] r;
    r = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_tag[p*ROB_IDX_W +: ROB_IDX_W] == tag))
        r = {1'b1, cdb_data[p*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [XLEN:0] lk_in1, lk_in2, lk_h1, lk_h2;
  assign lk_in1 = cdb_lookup(in_rs1_tag);
  assign lk_in2 = cdb_lookup(in_rs2_tag);
  assign lk_h1  = cdb_lookup(rs1_tag_q);
  assign lk_h2  = cdb_lookup(rs2_tag_q);

  // Operand values as they would be captured at accept.
  logic            cap1_ready, cap2_ready;
  logic [XLEN-1:0] cap1_data, cap2_data;
  assign cap1_ready = in_rs1_ready | lk_in1[XLEN];
  assign cap1_data  = in_rs1_ready ? in_rs1_data : lk_in1[XLEN-1:0];
  assign cap2_ready = in_rs2_ready | lk_in2[XLEN];
  assign cap2_data  = in_rs2_ready ? in_rs2_data : lk_in2[XLEN-1:0];

  // Held operands with a same-cycle CDB forward. A ready operand is never
  // replaced; readiness comes only from the flag.
  logic            fwd1_ready, fwd2_ready;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
  assign fwd1_ready = rs1_ready_q | lk_h1[XLEN];
  assign fwd1_data  = (!rs1_ready_q && lk_h1[XLEN]) ? lk_h1[XLEN-1:0] : rs1_data_q;
  assign fwd2_ready = rs2_ready_q | lk_h2[XLEN];
  assign fwd2_data  = (!rs2_ready_q && lk_h2[XLEN]) ? lk_h2[XLEN-1:0] : rs2_data_q;

  logic              held, fire, legal, accept, bypass;
  logic [NUM_CH-1:0] held_valid;

  assign held  = (state_q == HELD);
  assign legal = ({1'b0, in_ch} < (CH_SEL_W + 1)'(NUM_CH));

  always_comb begin
    held_valid = '0;
    for (int c = 0; c < NUM_CH; c++)
      held_valid[c] = held & ~flush & (ch_q == CH_SEL_W'(c));
  end

  assign fire     = |(held_valid & out_ready);
  // rst_n is included so the upstream sees no ready while reset is applied.
  assign in_ready = rst_n & ~flush & (~held | fire);
  assign accept   = in_valid & in_ready;

`ifdef DISPATCH_BYPASS_EN
  logic [NUM_CH-1:0] in_sel;
  always_comb begin
    in_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      in_sel[c] = (in_ch == CH_SEL_W'(c));
  end
  assign bypass    = accept & ~held & legal & |(in_sel & out_ready);
  assign out_valid = held_valid | (bypass ? in_sel : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = held_valid;
`endif

  assign out_payload   = bypass ? in_payload : payload_q;
  assign out_rs1_tag   = bypass ? in_rs1_tag : rs1_tag_q;
  assign out_rs2_tag   = bypass ? in_rs2_tag : rs2_tag_q;
  assign out_rs1_ready = bypass ? cap1_ready : fwd1_ready;
  assign out_rs1_data  = bypass ? cap1_data  : fwd1_data;
  assign out_rs2_ready = bypass ? cap2_ready : fwd2_ready;
  assign out_rs2_data  = bypass ? cap2_data  : fwd2_data;
  assign err_illegal   = err_q;

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    ch_d        = ch_q;
    rs1_tag_d   = rs1_tag_q;
    rs2_tag_d   = rs2_tag_q;
    // A waiting entry keeps absorbing CDB results.
    rs1_ready_d = held ? fwd1_ready : rs1_ready_q;
    rs1_data_d  = held ? fwd1_data  : rs1_data_q;
    rs2_ready_d = held ? fwd2_ready : rs2_ready_q;
    rs2_data_d  = held ? fwd2_data  : rs2_data_q;
    err_d       = 1'b0;

    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      err_d = ~legal;
      if (legal && !bypass) begin
        state_d     = HELD;
        payload_d   = in_payload;
        ch_d        = in_ch;
        rs1_tag_d   = in_rs1_tag;
        rs2_tag_d   = in_rs2_tag;
        rs1_ready_d = cap1_ready;
        rs1_data_d  = cap1_data;
        rs2_ready_d = cap2_ready;
        rs2_data_d  = cap2_data;
      end else begin
        state_d = EMPTY;
      end
    end else if (fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      payload_q   <= '0;
      ch_q        <= '0;
      rs1_tag_q   <= '0;
      rs2_tag_q   <= '0;
      rs1_ready_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_ready_q <= 1'b0;
      rs2_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      ch_q        <= ch_d;
      rs1_tag_q   <= rs1_tag_d;
      rs2_tag_q   <= rs2_tag_d;
      rs1_ready_q <= rs1_ready_d;
      rs1_data_q  <= rs1_data_d;
      rs2_ready_q <= rs2_ready_d;
      rs2_data_q  <= rs2_data_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_router
//  Purpose  : Directed self-checking bench for dispatch_router in its default
//             (registered, non-bypass) build, instantiated with NUM_CH=3 so
//             that channel 3 is out of range.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_router;

  localparam int NUM_CH = 3;

  logic         clk, rst_n, flush;
  logic         in_valid, in_ready;
  logic [1:0]   in_ch;
  logic [127:0] in_payload;
  logic [4:0]   in_rs1_tag, in_rs2_tag;
  logic         in_rs1_ready, in_rs2_ready;
  logic [31:0]  in_rs1_data, in_rs2_data;
  logic [2:0]   cdb_valid;
  logic [14:0]  cdb_tag;
  logic [95:0]  cdb_data;
  logic [2:0]   out_valid, out_ready;
  logic [127:0] out_payload;
  logic [4:0]   out_rs1_tag, out_rs2_tag;
  logic         out_rs1_ready, out_rs2_ready;
  logic [31:0]  out_rs1_data, out_rs2_data;
  logic         err_illegal;

  int n_checks = 0;
  int n_err    = 0;

  dispatch_router #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_payload(in_payload),
    .in_rs1_tag(in_rs1_tag), .in_rs1_ready(in_rs1_ready), .in_rs1_data(in_rs1_data),
    .in_rs2_tag(in_rs2_tag), .in_rs2_ready(in_rs2_ready), .in_rs2_data(in_rs2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rs1_tag(out_rs1_tag), .out_rs1_ready(out_rs1_ready), .out_rs1_data(out_rs1_data),
    .out_rs2_tag(out_rs2_tag), .out_rs2_ready(out_rs2_ready), .out_rs2_data(out_rs2_data),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [127:0] pl,
                       input logic [4:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [4:0] t2, input logic r2, input logic [31:0] d2);
    in_valid = v; in_ch = ch; in_payload = pl;
    in_rs1_tag = t1; in_rs1_ready = r1; in_rs1_data = d1;
    in_rs2_tag = t2; in_rs2_ready = r2; in_rs2_data = d2;
  endtask

  logic [1:0]   chs [4];
  logic [127:0] pls [4];

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    drive(1'b0, 2'd0, '0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    #2;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_err", err_illegal, 0);
    check("reset_data", out_payload, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    #2 check("post_reset_in_ready", in_ready, 1);

    // Ready operands, channel 1, one-cycle latency.
    drive(1'b1, 2'd1, 128'h1234, 5'd3, 1'b1, 32'h5, 5'd4, 1'b1, 32'h0);
    out_ready = 3'b010;
    #2 check("t2_no_same_cycle_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    #2;
    check("t2_out_valid", out_valid, 3'b010);
    check("t2_rs1_data", out_rs1_data, 32'h5);
    check("t2_rs2_ready", out_rs2_ready, 1);
    check("t2_rs2_data", out_rs2_data, 32'h0);
    check("t2_payload", out_payload, 128'h1234);
    tick();
    out_ready = '0;
    #2 check("t2_empty_after_fire", out_valid, 0);

    // Stall and snoop. At accept, rs2 (tag 9) matches ports 1 and 2: port 1 wins.
    drive(1'b1, 2'd0, 128'hC0DE, 5'd7, 1'b0, 32'hDEAD, 5'd9, 1'b0, 32'h0);
    cdb_valid = 3'b110;
    cdb_tag   = {5'd9, 5'd9, 5'd0};
    cdb_data  = {32'hB2, 32'hB1, 32'h0};
    tick();
    in_valid = 1'b0; cdb_valid = '0;
    #2;
    check("t3_held_valid", out_valid, 3'b001);
    check("t3_in_ready_stall", in_ready, 0);
    check("t3_rs1_not_ready", out_rs1_ready, 0);
    check("t3_rs2_lowest_port", out_rs2_data, 32'hB1);
    check("t3_rs1_tag", out_rs1_tag, 5'd7);
    tick();
    tick();
    cdb_valid = 3'b101;
    cdb_tag   = {5'd7, 5'd0, 5'd6};
    cdb_data  = {32'hABCD, 32'h0, 32'h1111};
    #2;
    check("t3_fwd_ready", out_rs1_ready, 1);
    check("t3_fwd_data", out_rs1_data, 32'hABCD);
    tick();
    cdb_valid = '0;
    #2;
    check("t3_snooped_data", out_rs1_data, 32'hABCD);
    check("t3_snooped_ready", out_rs1_ready, 1);
    tick();
    out_ready = 3'b001;
    #2;
    check("t3_fire_valid", out_valid, 3'b001);
    check("t3_fire_in_ready", in_ready, 1);
    tick();
    out_ready = '0;
    #2 check("t3_empty", out_valid, 0);

    // Back-to-back, alternating channels.
    chs[0] = 2'd0; chs[1] = 2'd1; chs[2] = 2'd0; chs[3] = 2'd1;
    pls[0] = 128'hA0; pls[1] = 128'hA1; pls[2] = 128'hA2; pls[3] = 128'hA3;
    out_ready = 3'b111;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, chs[k], pls[k], 5'd1, 1'b1, 32'd0, 5'd2, 1'b1, 32'd0);
      else in_valid = 1'b0;
      #2;
      check("t4_in_ready", in_ready, 1);
      if (k == 0) check("t4_first_idle", out_valid, 0);
      else begin
        check("t4_valid", out_valid, 3'b001 << chs[k-1]);
        check("t4_order", out_payload, pls[k-1]);
      end
      tick();
    end
    #2 check("t4_drained", out_valid, 0);
    out_ready = '0;

    // Flush while held with the channel ready.
    drive(1'b1, 2'd2, 128'hF1, 5'd1, 1'b1, 32'd1, 5'd2, 1'b1, 32'd2);
    tick();
    drive(1'b1, 2'd0, 128'hF2, 5'd1, 1'b1, 32'd1, 5'd2, 1'b1, 32'd2);
    out_ready = 3'b100; flush = 1'b1;
    #2;
    check("t5_flush_no_fire", out_valid, 0);
    check("t5_flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #2;
    check("t5_empty_after_flush", out_valid, 0);
    check("t5_in_ready_after", in_ready, 1);
    out_ready = '0;

    // Illegal channel.
    drive(1'b1, 2'd3, 128'hBAD, 5'd1, 1'b1, 32'd1, 5'd2, 1'b1, 32'd2);
    out_ready = 3'b111;
    #2;
    check("t6_err_before", err_illegal, 0);
    check("t6_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #2;
    check("t6_err_pulse", err_illegal, 1);
    check("t6_no_valid", out_valid, 0);
    tick();
    #2;
    check("t6_err_single", err_illegal, 0);
    check("t6_still_empty", out_valid, 0);
    out_ready = '0;

    // Asynchronous reset while an entry is held.
    drive(1'b1, 2'd1, 128'h77, 5'd1, 1'b1, 32'd1, 5'd2, 1'b1, 32'd2);
    tick();
    in_valid = 1'b0;
    #2 check("t1_held", out_valid, 3'b010);
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", out_valid, 0);
    check("t1_rst_in_ready", in_ready, 0);
    check("t1_rst_payload", out_payload, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    out_ready = 3'b010;
    #2;
    check("t1_entry_lost", out_valid, 0);
    check("t1_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
